gray_decode_monitor: RTL and testbench

// - Downstream stage of the binary-to-Gray encoder: accepts a stream of W-bit Gray codes, registers
//   the decoded binary value, and checks that successive codes form a valid single-bit-step sequence.
// - Reports the step direction and flags non-adjacent transitions.
// - Keeps a saturating error counter for the bench and status logic.

---
 rtl/gray_decode_monitor.sv | 116 +++++++++++
 tb/tb_gray_decode_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_decode_monitor.sv
// Decodes a stream of Gray codes to binary, classifies each step against the previous code
// (up / down / repeat / non-adjacent), and keeps a saturating count of non-adjacent steps.
module gray_decode_monitor #(
  parameter int W  = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_gray,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_bin,
  output logic          out_up,
  output logic          out_down,
  output logic          out_rep,
  output logic          adj_err,
  output logic [CW-1:0] err_count,
  input  logic          clear
);

  typedef enum logic {NOREF, TRACK} state_t;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_t        state, state_nxt;
  logic [W-1:0]  prev_gray, prev_gray_nxt;
  logic [W-1:0]  diff, dec_bin, prev_inc;
  logic          accept, one_bit;
  logic          vld_nxt, up_nxt, down_nxt, rep_nxt, err_nxt;
  logic [W-1:0]  bin_nxt;
  logic [CW-1:0] cnt_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign diff     = in_gray ^ prev_gray;
  assign one_bit  = (diff != '0) && ((diff & (diff - 1'b1)) == '0);
  assign dec_bin  = gray2bin(in_gray);
  assign prev_inc = gray2bin(prev_gray) + 1'b1;

  always_comb begin
    state_nxt     = state;
    prev_gray_nxt = prev_gray;
    vld_nxt       = out_valid && !out_ready;
    bin_nxt       = out_bin;
    up_nxt        = out_up;
    down_nxt      = out_down;
    rep_nxt       = out_rep;
    err_nxt       = adj_err;
    cnt_nxt       = err_count;
    if (accept) begin
      vld_nxt       = 1'b1;
      bin_nxt       = dec_bin;
      up_nxt        = 1'b0;
      down_nxt      = 1'b0;
      rep_nxt       = 1'b0;
      err_nxt       = 1'b0;
      prev_gray_nxt = in_gray;
      state_nxt     = TRACK;
      // A clear in the accept cycle turns this sample into a fresh reference.
      if (state == TRACK && !clear) begin
        if (diff == '0) begin
          rep_nxt = 1'b1;
        end else if (one_bit) begin
          up_nxt   = (dec_bin == prev_inc);
          down_nxt = (dec_bin != prev_inc);
        end else begin
          err_nxt = 1'b1;
          cnt_nxt = sat_inc(err_count);
        end
      end
    end
    if (clear) begin
      cnt_nxt = '0;
      if (!accept) state_nxt = NOREF;
    end
  end

  // Output stage: holds the decoded sample until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= NOREF;
      prev_gray <= '0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_up    <= 1'b0;
      out_down  <= 1'b0;
      out_rep   <= 1'b0;
      adj_err   <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      prev_gray <= prev_gray_nxt;
      out_valid <= vld_nxt;
      out_bin   <= bin_nxt;
      out_up    <= up_nxt;
      out_down  <= down_nxt;
      out_rep   <= rep_nxt;
      adj_err   <= err_nxt;
      err_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_gray_decode_monitor.sv
// Bench for gray_decode_monitor (W=3, CW=2): table of Gray codes with expected decode,
// queued on accept and compared when the output handshake completes.
module tb_gray_decode_monitor;
  localparam int W  = 3;
  localparam int CW = 2;
  localparam logic [3:0] F0 = 4'b0000, FU = 4'b1000, FD = 4'b0100, FR = 4'b0010, FE = 4'b0001;

  typedef struct {
    logic [W-1:0]  gray;
    logic [W-1:0]  bin;
    logic [3:0]    flg;
    logic [CW-1:0] err;
  } vec_t;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, clear;
  logic out_up, out_down, out_rep, adj_err;
  logic [W-1:0] in_gray, out_bin;
  logic [CW-1:0] err_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  vec_t exp_q[$];
  vec_t tbl[19];

  always #5 clk = ~clk;

  gray_decode_monitor #(.W(W), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .out_up(out_up),
    .out_down(out_down), .out_rep(out_rep), .adj_err(adj_err), .err_count(err_count),
    .clear(clear)
  );

  function automatic vec_t mk(input logic [W-1:0] g, input logic [W-1:0] b,
                              input logic [3:0] f, input logic [CW-1:0] e);
    vec_t v;
    v.gray = g; v.bin = b; v.flg = f; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v, input logic clr);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_gray  = v.gray;
    clear    = clr;
    #1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      clear    = 1'b0;
    end else begin
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      clear = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_gray  = W'($urandom);
    end
  endtask

  // Scoreboard: compare whenever a sample is handed over at the coming edge.
  always begin
    @(negedge clk);
    #2;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk($sformatf("bin#%0d", n_out), 32'(out_bin), 32'(e.bin));
        chk($sformatf("flags#%0d", n_out), 32'({out_up, out_down, out_rep, adj_err}), 32'(e.flg));
        chk($sformatf("err_count#%0d", n_out), 32'(err_count), 32'(e.err));
      end
      n_out++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(3'b000, 3'd0, F0, 2'd0);
    tbl[1]  = mk(3'b001, 3'd1, FU, 2'd0);
    tbl[2]  = mk(3'b011, 3'd2, FU, 2'd0);
    tbl[3]  = mk(3'b010, 3'd3, FU, 2'd0);
    tbl[4]  = mk(3'b110, 3'd4, FU, 2'd0);
    tbl[5]  = mk(3'b111, 3'd5, FU, 2'd0);
    tbl[6]  = mk(3'b101, 3'd6, FU, 2'd0);
    tbl[7]  = mk(3'b100, 3'd7, FU, 2'd0);
    tbl[8]  = mk(3'b101, 3'd6, FD, 2'd0);
    tbl[9]  = mk(3'b111, 3'd5, FD, 2'd0);
    tbl[10] = mk(3'b110, 3'd4, FD, 2'd0);
    tbl[11] = mk(3'b010, 3'd3, FD, 2'd0);
    tbl[12] = mk(3'b011, 3'd2, FD, 2'd0);
    tbl[13] = mk(3'b001, 3'd1, FD, 2'd0);
    tbl[14] = mk(3'b000, 3'd0, FD, 2'd0);
    tbl[15] = mk(3'b100, 3'd7, FD, 2'd0);
    tbl[16] = mk(3'b000, 3'd0, FU, 2'd0);
    tbl[17] = mk(3'b011, 3'd2, FE, 2'd1);
    tbl[18] = mk(3'b011, 3'd2, FR, 2'd1);

    reset = 1'b1; in_valid = 1'b0; in_gray = '0; out_ready = 1'b1; clear = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bin", 32'(out_bin), 32'd0);
    chk("rst_flags", 32'({out_up, out_down, out_rep, adj_err}), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Up run, down run, both wraps, non-adjacent step, repeat.
    for (int i = 0; i < 19; i++) drive(tbl[i], 1'b0);
    idle(3);

    // Back-pressure: A waits, B is blocked for 3 cycles, then B and C flow.
    out_ready = 1'b0;
    drive(mk(3'b010, 3'd3, FU, 2'd1), 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_gray  = 3'b110;
      #1;
      chk($sformatf("stall_in_ready%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("stall_out_valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall_out_bin%0d", k), 32'(out_bin), 32'd3);
    end
    out_ready = 1'b1;
    #0;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(mk(3'b110, 3'd4, FU, 2'd1));
    @(posedge clk);
    #1;
    drive(mk(3'b111, 3'd5, FU, 2'd1), 1'b0);
    idle(3);

    // Saturation with CW=2, then clear together with an accept.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("clear_err_count", 32'(err_count), 32'd0);
    drive(mk(3'b000, 3'd0, F0, 2'd0), 1'b0);
    drive(mk(3'b011, 3'd2, FE, 2'd1), 1'b0);
    drive(mk(3'b101, 3'd6, FE, 2'd2), 1'b0);
    drive(mk(3'b010, 3'd3, FE, 2'd3), 1'b0);
    drive(mk(3'b100, 3'd7, FE, 2'd3), 1'b0);
    drive(mk(3'b111, 3'd5, FE, 2'd3), 1'b0);
    drive(mk(3'b000, 3'd0, F0, 2'd0), 1'b1);
    drive(mk(3'b001, 3'd1, FU, 2'd0), 1'b0);
    idle(3);

    // Asynchronous reset while an output is pending.
    out_ready = 1'b0;
    drive(mk(3'b111, 3'd5, FE, 2'd1), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pending_out_valid", 32'(out_valid), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_err_count", 32'(err_count), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    drive(mk(3'b101, 3'd6, F0, 2'd0), 1'b0);
    drive(mk(3'b100, 3'd7, FU, 2'd0), 1'b0);
    idle(4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
